// File: rtl/voting_session.sv
// voting_session: N-voter session controller with first-cast locking, a serial tally and a registered one-hot result.
// Optional feature: define VOTING_QUORUM_EN to require at least QUORUM casts for a valid result.
module voting_session #(
    parameter int N_VOTERS = 4,
    parameter int QUORUM   = 3,
    localparam int CW      = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                open_i,
    input  logic                close_i,
    input  logic [N_VOTERS-1:0] cast_i,
    input  logic [N_VOTERS-1:0] choice_i,
    output logic [3:1]          O,
    output logic [CW-1:0]       yes_count,
    output logic [N_VOTERS-1:0] voted_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                no_quorum_o
);

    // state   | meaning
    // IDLE    | after reset, no session yet
    // OPEN    | casting window, first cast per voter is locked
    // COUNT   | serial tally, one voter per cycle
    // RESOLVE | register result and pulse done
    // DONE    | hold result until the next open

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_COUNT,
        S_RESOLVE,
        S_DONE
    } state_t;

    localparam int            IW       = $clog2(N_VOTERS);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_VOTERS - 1);
    localparam logic [CW:0]   N_WIDE   = (CW + 1)'(N_VOTERS);

    if (N_VOTERS < 2 || N_VOTERS > 32 || QUORUM < 1 || QUORUM > N_VOTERS) begin : g_param_check
        $error("voting_session: N_VOTERS or QUORUM out of legal range");
    end

    state_t              state, state_nxt;
    logic [IW-1:0]       idx;
    logic [N_VOTERS-1:0] voted_r;
    logic [N_VOTERS-1:0] choice_r;
    logic [CW-1:0]       yes_r;
    logic [3:1]          result_r;
    logic [3:1]          result_nxt;
    logic [CW:0]         yes_x2;
    logic                done_r;
    logic                nq_r;
    logic                nq_nxt;
`ifdef VOTING_QUORUM_EN
    logic [CW-1:0]       casts_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (open_i) state_nxt = S_OPEN;
            S_OPEN:         if (close_i) state_nxt = S_COUNT;
            S_COUNT:        if (idx == LAST_IDX) state_nxt = S_RESOLVE;
            S_RESOLVE:      state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Doubling the tally into CW+1 bits keeps the majority compare overflow-free.
    always_comb begin
        yes_x2     = {yes_r, 1'b0};
        result_nxt = 3'b100;
        nq_nxt     = 1'b0;
        if (yes_x2 < N_WIDE) begin
            result_nxt = 3'b001;
        end else if (yes_x2 == N_WIDE) begin
            result_nxt = 3'b010;
        end
`ifdef VOTING_QUORUM_EN
        if (casts_r < CW'(QUORUM)) begin
            result_nxt = 3'b000;
            nq_nxt     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            voted_r  <= '0;
            choice_r <= '0;
            yes_r    <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
            nq_r     <= 1'b0;
`ifdef VOTING_QUORUM_EN
            casts_r  <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (open_i) begin
                        idx      <= '0;
                        voted_r  <= '0;
                        choice_r <= '0;
                        yes_r    <= '0;
                        result_r <= '0;
                        nq_r     <= 1'b0;
`ifdef VOTING_QUORUM_EN
                        casts_r  <= '0;
`endif
                    end
                end
                S_OPEN: begin
                    // Locked voters keep their first choice; only fresh casts are latched.
                    voted_r  <= voted_r | cast_i;
                    choice_r <= (choice_r & voted_r) | (choice_i & cast_i & ~voted_r);
                    idx      <= '0;
                end
                S_COUNT: begin
                    yes_r <= yes_r + CW'(voted_r[idx] & choice_r[idx]);
`ifdef VOTING_QUORUM_EN
                    casts_r <= casts_r + CW'(voted_r[idx]);
`endif
                    idx <= idx + 1'b1;
                end
                S_RESOLVE: begin
                    result_r <= result_nxt;
                    nq_r     <= nq_nxt;
                    done_r   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign O           = result_r;
    assign yes_count   = yes_r;
    assign voted_o     = voted_r;
    assign busy_o      = (state == S_COUNT) || (state == S_RESOLVE);
    assign done_o      = done_r;
    assign no_quorum_o = nq_r;

endmodule
